// File: rtl/whr_ip_buf_mac.sv
// -----------------------------------------------------------------------------
// whr_ip_buf_mac -- wormhole router input port buffer (single VC).
//
// Terminates the channel from an upstream output port controller and stores
// flits in a FIFO of buffer_size entries. The head-of-queue flit is presented
// combinationally to the switch allocator/crossbar. One credit pulse is
// returned upstream for every flit that leaves the FIFO.
//
// Optional feature macro: WHR_IP_BUF_ERROR_CHECK_EN
//   defined   : ingress head/tail framing FSM, overflow and framing error
//               detection, and the sticky error register are built in.
//   undefined : that logic is absent and error is tied to 0. Overflow flits
//               are still dropped without any state change.
//
// Parameters
//   buffer_size     FIFO depth in flits (>= 2, any value)
//   flit_data_width payload width
//   port_id         informational input port ID
//
// Ports
//   clk            clock
//   reset          synchronous active-high reset
//   channel_in     {valid, head, tail, data}; valid is the MSB
//   flow_ctrl_out  registered credit pulse, one per popped flit
//   flit_valid_out head-of-queue flit valid (count != 0)
//   flit_head_out  head-of-queue head flag
//   flit_tail_out  head-of-queue tail flag
//   flit_data_out  head-of-queue payload
//   flit_ready_in  crossbar takes the head-of-queue flit this cycle
//   empty          FIFO holds no flits
//   error          sticky overflow/framing error
// -----------------------------------------------------------------------------
module whr_ip_buf_mac #(
    parameter int buffer_size     = 8,
    parameter int flit_data_width = 64,
    parameter int port_id         = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    // Bit order {valid, head, tail, data}: channel position 0 (valid) is the MSB.
    input  logic [flit_data_width+2:0] channel_in,
    output logic                       flow_ctrl_out,
    output logic                       flit_valid_out,
    output logic                       flit_head_out,
    output logic                       flit_tail_out,
    output logic [flit_data_width-1:0] flit_data_out,
    input  logic                       flit_ready_in,
    output logic                       empty,
    output logic                       error
);

    localparam int PTR_W  = $clog2(buffer_size);
    localparam int CNT_W  = $clog2(buffer_size + 1);
    localparam int WORD_W = flit_data_width + 2;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(buffer_size - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(buffer_size);

    // Reject unusable configurations at elaboration time.
    if (buffer_size < 2 || port_id < 0) begin : g_param_check
        $error("whr_ip_buf_mac: buffer_size must be >= 2 and port_id >= 0");
    end

    // Channel field decode
    logic                       w_in_valid;
    logic                       w_in_head;
    logic                       w_in_tail;
    logic [flit_data_width-1:0] w_in_data;

    assign w_in_valid = channel_in[flit_data_width+2];
    assign w_in_head  = channel_in[flit_data_width+1];
    assign w_in_tail  = channel_in[flit_data_width];
    assign w_in_data  = channel_in[flit_data_width-1:0];

    // Storage and pointers
    logic [WORD_W-1:0] r_mem [buffer_size];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_flow_ctrl;

    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [WORD_W-1:0] w_rd_word;

    assign flit_valid_out = (r_count != {CNT_W{1'b0}});
    assign empty          = (r_count == {CNT_W{1'b0}});
    assign w_full         = (r_count == FULL_CNT);
    assign w_pop          = flit_valid_out & flit_ready_in;
    // When full, a push is only taken if a pop frees the slot in the same cycle.
    assign w_accept       = w_in_valid & (~w_full | w_pop);

    // Pointer increment with explicit wrap (depth need not be a power of two).
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        if (r_wr_ptr == PTR_LAST) begin
            w_wr_ptr_nxt = {PTR_W{1'b0}};
        end else begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end
        if (r_rd_ptr == PTR_LAST) begin
            w_rd_ptr_nxt = {PTR_W{1'b0}};
        end else begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
    end

    // Flit storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_mem[r_wr_ptr] <= {w_in_head, w_in_tail, w_in_data};
        end
    end

    // Pointers, occupancy and credit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_flow_ctrl <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_flow_ctrl <= w_pop;
        end
    end

    assign flow_ctrl_out = r_flow_ctrl;

    // Head-of-queue read is combinational from the read pointer.
    assign w_rd_word     = r_mem[r_rd_ptr];
    assign flit_head_out = w_rd_word[WORD_W-1];
    assign flit_tail_out = w_rd_word[WORD_W-2];
    assign flit_data_out = w_rd_word[flit_data_width-1:0];

`ifdef WHR_IP_BUF_ERROR_CHECK_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } frame_state_t;

    frame_state_t r_state;
    frame_state_t w_state_nxt;
    logic         w_frame_err;
    logic         w_overflow_err;
    logic         r_error;

    assign w_overflow_err = w_in_valid & w_full & ~w_pop;

    // Framing FSM next state; a misframed flit flags an error but keeps the state.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_err = 1'b0;
        if (w_in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_in_head) begin
                        w_frame_err = 1'b1;
                    end else if (!w_in_tail) begin
                        w_state_nxt = ST_PKT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_PKT: begin
                    if (w_in_head) begin
                        w_frame_err = 1'b1;
                    end else if (w_in_tail) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_PKT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Framing state register and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_error <= r_error | w_overflow_err | w_frame_err;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_whr_ip_buf_mac.sv
module tb_whr_ip_buf_mac;

`ifdef WHR_IP_BUF_ERROR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: depth 8, 64-bit payload
    logic        rst8;
    logic [66:0] ch8;
    logic        rdy8;
    logic        cred8, val8, head8, tail8, empty8, err8;
    logic [63:0] data8;

    whr_ip_buf_mac #(.buffer_size(8), .flit_data_width(64), .port_id(0)) dut8 (
        .clk(clk), .reset(rst8), .channel_in(ch8), .flow_ctrl_out(cred8),
        .flit_valid_out(val8), .flit_head_out(head8), .flit_tail_out(tail8),
        .flit_data_out(data8), .flit_ready_in(rdy8), .empty(empty8), .error(err8)
    );

    // Instance B: depth 5 (non power of two), 16-bit payload
    logic        rst5;
    logic [18:0] ch5;
    logic        rdy5;
    logic        cred5, val5, head5, tail5, empty5, err5;
    logic [15:0] data5;

    whr_ip_buf_mac #(.buffer_size(5), .flit_data_width(16), .port_id(1)) dut5 (
        .clk(clk), .reset(rst5), .channel_in(ch5), .flow_ctrl_out(cred5),
        .flit_valid_out(val5), .flit_head_out(head5), .flit_tail_out(tail5),
        .flit_data_out(data5), .flit_ready_in(rdy5), .empty(empty5), .error(err5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset8();
        rst8 = 1'b1; ch8 = '0; rdy8 = 1'b0;
        next_cycle();
        rst8 = 1'b0;
    endtask

    typedef struct {
        logic        v, h, t;
        logic [63:0] d;
        logic        rdy;
        logic        e_valid, e_head, e_tail;
        logic [63:0] e_data;
        logic        e_empty, e_credit;
    } vec_t;

    vec_t vt [9];
    int   credits;

    initial begin
        // {v,h,t,data,rdy, exp valid,head,tail,data,empty,credit}
        vt[0] = '{1'b1, 1'b1, 1'b1, 64'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b1, 64'hA5, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 64'h22, 1'b1, 1'b1, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b1, 64'h22, 1'b0, 1'b1};
        vt[7] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1};
        vt[8] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0};

        rst5 = 1'b1; ch5 = '0; rdy5 = 1'b0;
        reset8();
        rst5 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_valid", {63'd0, val8}, 64'd0);
        chk("reset_empty", {63'd0, empty8}, 64'd1);
        chk("reset_credit", {63'd0, cred8}, 64'd0);
        chk("reset_error", {63'd0, err8}, 64'd0);
        next_cycle();

        // Single-flit packet, then a head/tail packet with push+pop overlap
        for (int i = 0; i < 9; i++) begin
            ch8  = {vt[i].v, vt[i].h, vt[i].t, vt[i].d};
            rdy8 = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {63'd0, val8}, {63'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_empty", i), {63'd0, empty8}, {63'd0, vt[i].e_empty});
            chk($sformatf("vec%0d_credit", i), {63'd0, cred8}, {63'd0, vt[i].e_credit});
            chk($sformatf("vec%0d_error", i), {63'd0, err8}, 64'd0);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_head", i), {63'd0, head8}, {63'd0, vt[i].e_head});
                chk($sformatf("vec%0d_tail", i), {63'd0, tail8}, {63'd0, vt[i].e_tail});
                chk($sformatf("vec%0d_data", i), data8, vt[i].e_data);
            end
            next_cycle();
        end

        // Fill 8, overflow with a 9th, drain
        reset8();
        for (int i = 0; i < 8; i++) begin
            ch8 = {3'b111, 64'h100 + 64'(i)};
            next_cycle();
        end
        ch8 = {3'b111, 64'h1FF};
        @(negedge clk);
        chk("fill_full_error_before", {63'd0, err8}, 64'd0);
        chk("fill_full_data", data8, 64'h100);
        next_cycle();
        ch8 = '0; rdy8 = 1'b1; credits = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) chk("overflow_error", {63'd0, err8}, {63'd0, ERR_EN});
            if (k < 8) begin
                chk($sformatf("drain%0d_valid", k), {63'd0, val8}, 64'd1);
                chk($sformatf("drain%0d_data", k), data8, 64'h100 + 64'(k));
            end else begin
                chk($sformatf("drain%0d_valid", k), {63'd0, val8}, 64'd0);
            end
            if (cred8) credits++;
            next_cycle();
        end
        chk("drain_credits", 64'(credits), 64'd8);
        rdy8 = 1'b0;

        // Full FIFO with simultaneous push and pop
        reset8();
        for (int i = 0; i < 8; i++) begin
            ch8 = {3'b111, 64'h200 + 64'(i)};
            next_cycle();
        end
        ch8 = {3'b111, 64'h2FF}; rdy8 = 1'b1;
        @(negedge clk);
        chk("fullpp_data", data8, 64'h200);
        next_cycle();
        ch8 = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 7) begin
                chk($sformatf("fullpp%0d_data", k), data8, 64'h201 + 64'(k));
            end else if (k == 7) begin
                chk("fullpp_new_data", data8, 64'h2FF);
                chk("fullpp_new_valid", {63'd0, val8}, 64'd1);
            end else begin
                chk($sformatf("fullpp%0d_valid", k), {63'd0, val8}, 64'd0);
            end
            next_cycle();
        end
        chk("fullpp_error", {63'd0, err8}, 64'd0);
        rdy8 = 1'b0;

        // Framing: body flit while idle
        reset8();
        ch8 = {3'b100, 64'h33};
        @(negedge clk);
        chk("frame_body_err_same", {63'd0, err8}, 64'd0);
        next_cycle();
        ch8 = '0; rdy8 = 1'b1;
        @(negedge clk);
        chk("frame_body_err", {63'd0, err8}, {63'd0, ERR_EN});
        chk("frame_body_valid", {63'd0, val8}, 64'd1);
        chk("frame_body_data", data8, 64'h33);
        chk("frame_body_head", {63'd0, head8}, 64'd0);
        next_cycle();
        rdy8 = 1'b0;

        // Framing: head, body, head
        reset8();
        ch8 = {3'b110, 64'h1}; next_cycle();
        ch8 = {3'b100, 64'h2}; next_cycle();
        ch8 = {3'b110, 64'h3};
        @(negedge clk);
        chk("frame_hbh_err_before", {63'd0, err8}, 64'd0);
        next_cycle();
        ch8 = '0; rdy8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) chk("frame_hbh_err", {63'd0, err8}, {63'd0, ERR_EN});
            chk($sformatf("frame_hbh%0d_data", k), data8, 64'(k + 1));
            next_cycle();
        end
        rdy8 = 1'b0;

        // Reset mid-packet with a pop and a flit in the reset cycle
        reset8();
        ch8 = {3'b110, 64'h40}; next_cycle();
        ch8 = {3'b100, 64'h41}; next_cycle();
        ch8 = {3'b100, 64'h42}; next_cycle();
        rst8 = 1'b1; rdy8 = 1'b1; ch8 = {3'b100, 64'h43};
        next_cycle();
        rst8 = 1'b0; ch8 = '0; rdy8 = 1'b0;
        @(negedge clk);
        chk("midrst_empty", {63'd0, empty8}, 64'd1);
        chk("midrst_valid", {63'd0, val8}, 64'd0);
        chk("midrst_credit", {63'd0, cred8}, 64'd0);
        chk("midrst_error", {63'd0, err8}, 64'd0);
        next_cycle();
        ch8 = {3'b110, 64'h50};
        next_cycle();
        ch8 = '0;
        @(negedge clk);
        chk("midrst_new_valid", {63'd0, val8}, 64'd1);
        chk("midrst_new_data", data8, 64'h50);
        chk("midrst_new_head", {63'd0, head8}, 64'd1);
        chk("midrst_new_credit", {63'd0, cred8}, 64'd0);
        next_cycle();
        @(negedge clk);
        chk("midrst_new_error", {63'd0, err8}, 64'd0);
        next_cycle();

        // Streaming through depth-5 instance: 20 flits, ready held high
        rdy5 = 1'b1; credits = 0;
        for (int i = 0; i < 23; i++) begin
            if (i < 20) ch5 = {3'b111, 16'h300 + 16'(i)};
            else        ch5 = '0;
            @(negedge clk);
            if (i == 0) begin
                chk("stream_first_valid", {63'd0, val5}, 64'd0);
            end else if (i <= 20) begin
                chk($sformatf("stream%0d_valid", i), {63'd0, val5}, 64'd1);
                chk($sformatf("stream%0d_data", i), {48'd0, data5}, 64'h300 + 64'(i - 1));
            end else begin
                chk($sformatf("stream%0d_empty", i), {63'd0, empty5}, 64'd1);
            end
            if (cred5) credits++;
            next_cycle();
        end
        chk("stream_credits", 64'(credits), 64'd20);
        chk("stream_error", {63'd0, err5}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/whr_ip_buf_mac.md
# whr_ip_buf_mac

Input port buffer for the wormhole router. It terminates the incoming channel driven by an upstream router's output port controller and stores flits in a single-VC FIFO. It presents the head-of-queue flit to the switch allocator/crossbar and returns one credit upstream per dequeued flit. It also checks head/tail framing on ingress.

## Interface
- `buffer_size`, default 8: FIFO depth in flits; must be ≥ 2; need not be a power of two.
- `flit_data_width`, default 64: width of the flit payload.
- `port_id`, default 0: ID of this input port; informational only.

Channel format (MSB-first, `[0:channel_width-1]`), with `channel_width = 3 + flit_data_width`:
- bit 0: valid
- bit 1: head
- bit 2: tail
- bits 3 and up: data

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous reset, active-high.
- `channel_in`  in  channel_width  incoming flit channel.
- `flow_ctrl_out`  out  1  credit return to upstream; a 1-cycle pulse means one credit.
- `flit_valid_out`  out  1  head-of-queue flit valid.
- `flit_head_out`  out  1  head-of-queue flit is a head flit.
- `flit_tail_out`  out  1  head-of-queue flit is a tail flit.
- `flit_data_out`  out  flit_data_width  head-of-queue payload.
- `flit_ready_in`  in  1  crossbar accepts the head-of-queue flit this cycle.
- `empty`  out  1  FIFO holds no flits.
- `error`  out  1  sticky protocol/overflow error.

## Operation
- **Push**: occurs when channel valid = 1. The flit {head, tail, data} is written at `wr_ptr`, then `wr_ptr` advances.
- **Pop**: occurs when `flit_valid_out & flit_ready_in`. `rd_ptr` advances.
- **Pointer wrap**: each pointer wraps from `buffer_size-1` to 0 by explicit compare.
- **Occupancy**: `count`, `clogb(buffer_size+1)` bits.
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `flit_valid_out = (count != 0)`. `empty = (count == 0)`. Head, tail and data outputs are read combinationally from `rd_ptr` and are don't-care when `flit_valid_out = 0`.
- **Overflow**: push when `count == buffer_size` and no pop in the same cycle.
  - The flit is dropped; pointers and count are unchanged.
  - `overflow_err` is raised.
  - Push and pop together while full is legal.
- **Credit**: `flow_ctrl_out` is a register loaded with the pop condition. Exactly one pulse is produced per popped flit, in the cycle after the pop.
- **Ingress framing FSM**, states IDLE / PKT:
  - IDLE: head & ~tail → PKT. head & tail (single-flit packet) → stays IDLE. ~head → `frame_err`, state unchanged.
  - PKT: ~head & tail → IDLE. ~head & ~tail → stays PKT. head → `frame_err`, state unchanged.
  - The FSM advances only on valid flits. Flagged flits are still buffered.
- **Error**: `error` is the sticky OR of `overflow_err` and `frame_err`. It is cleared only by reset.

## Timing
- A flit on `channel_in` in cycle t is visible on `flit_valid_out` in cycle t+1. No same-cycle bypass.
- Pop in cycle t produces `flow_ctrl_out = 1` in cycle t+1.
- Minimum round-trip through this block is 2 cycles (ingress to credit).
- Full-throughput streaming: 1 flit/cycle in and out with `count` constant.
- **Reset** (synchronous, applies regardless of other inputs in that cycle):
  - `wr_ptr = rd_ptr = count = 0`, FSM = IDLE.
  - `flow_ctrl_out = 0`, `error = 0`, hence `flit_valid_out = 0` and `empty = 1`.
  - Flits and pops present in the reset cycle are discarded; no credit is produced for them.
  - Reset asserted mid-packet returns the FSM to IDLE.
- Storage array contents are not reset.

## Configuration
- `WHR_IP_BUF_ERROR_CHECK_EN`
  - Defined: the framing FSM, `overflow_err`/`frame_err` detection and the sticky error register are compiled in, behaving as above.
  - Undefined: all of that logic is removed and `error` is tied to 0. Overflow flits are still dropped with no state change. Buffering and credit behaviour are identical in both builds.

## Test plan
- **Single-flit packet**: reset, then one flit {head=1, tail=1, data=0xA5} in cycle 0 → `flit_valid_out=1` in cycle 1; with `flit_ready_in=1` in cycle 1, `flow_ctrl_out=1` in cycle 2 only; `empty=1` from cycle 2; `error=0`.
- **Fill**: `buffer_size=8`, 8 flits back-to-back with `flit_ready_in=0` → `count=8`. Then a 9th flit → flit dropped, `error=1` (macro defined) or `error=0` (undefined). Drain → exactly 8 credit pulses with data in order and no 9th flit.
- **Streaming and wrap**: `buffer_size=5`, 20 flits with `flit_ready_in=1` continuously → output data equals input data delayed by 1 cycle, 20 credits total, no error, pointers wrap 4 times.
- **Full push+pop**: full FIFO with push and pop in the same cycle → `count` stays 8, no error, the new flit appears after the 7 older flits.
- **Framing**: body flit {head=0, tail=0} while IDLE → `error=1` next cycle. Separately, head, body, head → `error=1`. Both flits are still delivered.
- **Reset mid-packet**: head flit plus 2 bodies buffered, pop asserted in the reset cycle → after reset `empty=1`, no credit pulse, `error=0`; a new head flit is accepted without error.
